wb_sequencer: RTL and testbench

Write-back sequencer for the multi-cycle RV32I core. It is the writing end of the register-file write port: it captures an instruction's result from execute, or waits for the load data response from data memory. It aligns and sign-extends load data, then issues exactly one write strobe to the register file on the rd_adr_wb / wbk_rd_reg_wb / wbk_data_wb interface. It also defers that write while the monitor owns the write port.

---
 rtl/wb_sequencer_if.sv | 33 +++
 rtl/wb_sequencer.sv | 132 +++++++++++++
 tb/tb_wb_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
// Write-back sequencer bus: execute capture, data-memory response, monitor
// arbitration and the register-file write port, bundled for wb_sequencer.
interface wb_sequencer_if;
    logic        stall;
    logic        cpu_stat_wb;
    logic [4:0]  rd_adr_ex;
    logic        rd_we_ex;
    logic        is_load_ex;
    logic [2:0]  funct3_ex;
    logic [1:0]  ld_adr_lo_ex;
    logic [31:0] alu_result_ex;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we_mon;
    logic        wb_run;
    logic        wb_done;
    logic [4:0]  rd_adr_wb;
    logic        wbk_rd_reg_wb;
    logic [31:0] wbk_data_wb;
    logic        ld_err;

    modport slave (
        input  stall, cpu_stat_wb, rd_adr_ex, rd_we_ex, is_load_ex, funct3_ex,
               ld_adr_lo_ex, alu_result_ex, dmem_rvalid, dmem_rdata, rf_we_mon,
        output wb_run, wb_done, rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, ld_err
    );

    modport master (
        output stall, cpu_stat_wb, rd_adr_ex, rd_we_ex, is_load_ex, funct3_ex,
               ld_adr_lo_ex, alu_result_ex, dmem_rvalid, dmem_rdata, rf_we_mon,
        input  wb_run, wb_done, rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, ld_err
    );
endinterface

// File: rtl/wb_sequencer.sv
// Write-back sequencer: captures an execute result or load response and issues
// one register-file write strobe. Optional load timeout via WB_LDTIMEOUT_EN.
module wb_sequencer #(
    parameter int LD_TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst_n,
    wb_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LDWAIT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_we_q, rd_we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  adr_lo_q, adr_lo_d;
    logic [31:0] data_q, data_d;
    logic        start;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
`ifdef WB_LDTIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        ld_err_q, ld_err_d;
`endif

    assign start = bus.cpu_stat_wb & ~bus.stall & (state_q == IDLE);

    // Formatting uses the captured funct3/address, so it is valid for the whole LDWAIT.
    always_comb begin
        ld_byte = bus.dmem_rdata[{adr_lo_q, 3'b000} +: 8];
        ld_half = adr_lo_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        rd_we_d  = rd_we_q;
        funct3_d = funct3_q;
        adr_lo_d = adr_lo_q;
        data_d   = data_q;
`ifdef WB_LDTIMEOUT_EN
        cnt_d    = cnt_q;
        ld_err_d = ld_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_d     = bus.rd_adr_ex;
                    rd_we_d  = bus.rd_we_ex;
                    funct3_d = bus.funct3_ex;
                    adr_lo_d = bus.ld_adr_lo_ex;
                    data_d   = bus.alu_result_ex;
                    state_d  = bus.is_load_ex ? LDWAIT : WRITE;
`ifdef WB_LDTIMEOUT_EN
                    cnt_d    = 8'd0;
                    ld_err_d = 1'b0;
`endif
                end
            end
            LDWAIT: begin
                if (bus.dmem_rvalid) begin
                    data_d  = ld_fmt;
                    state_d = WRITE;
                end
`ifdef WB_LDTIMEOUT_EN
                else if (cnt_q == 8'(LD_TIMEOUT)) begin
                    // Still write rd (with 0) so the core never stalls on a lost response.
                    data_d   = 32'd0;
                    ld_err_d = 1'b1;
                    state_d  = WRITE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            WRITE: begin
                if (!bus.rf_we_mon) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_q     <= 5'd0;
            rd_we_q  <= 1'b0;
            funct3_q <= 3'd0;
            adr_lo_q <= 2'd0;
            data_q   <= 32'd0;
`ifdef WB_LDTIMEOUT_EN
            cnt_q    <= 8'd0;
            ld_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            rd_we_q  <= rd_we_d;
            funct3_q <= funct3_d;
            adr_lo_q <= adr_lo_d;
            data_q   <= data_d;
`ifdef WB_LDTIMEOUT_EN
            cnt_q    <= cnt_d;
            ld_err_q <= ld_err_d;
`endif
        end
    end

    assign bus.rd_adr_wb     = rd_q;
    assign bus.wbk_data_wb   = data_q;
    assign bus.wbk_rd_reg_wb = (state_q == WRITE) & ~bus.rf_we_mon & rd_we_q & (rd_q != 5'd0);
    assign bus.wb_done       = (state_q == DONE);
    assign bus.wb_run        = (state_q != IDLE) | start;
`ifdef WB_LDTIMEOUT_EN
    assign bus.ld_err        = ld_err_q;
`else
    assign bus.ld_err        = 1'b0;
`endif
endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: ALU/x0/no-write paths, load formatting,
// load wait, monitor collision, stall, mid-load reset and optional timeout.
module tb_wb_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_strb = 0;
    int   strb_cyc = -1;
    logic [4:0]  strb_adr = '0;
    logic [31:0] strb_data = '0;
    int   n_done = 0;
    int   done_cyc = -1;
    int   run_low = 0;

    wb_sequencer_if bus();

    wb_sequencer #(.LD_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wbk_rd_reg_wb) begin
            n_strb    <= n_strb + 1;
            strb_cyc  <= cyc;
            strb_adr  <= bus.rd_adr_wb;
            strb_data <= bus.wbk_data_wb;
        end
        if (bus.wb_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // One operation: start at cycle t0, rvalid rv_dly cycles later (loads, 0 = never),
    // monitor owns the port for mon_n cycles from t0+1.
    task automatic do_op(input logic [4:0] rd, input logic we, input logic ld,
                         input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                         input int rv_dly, input logic [31:0] rdata, input int mon_n,
                         output int t0);
        nxt();
        bus.cpu_stat_wb   = 1'b1;
        bus.rd_adr_ex     = rd;
        bus.rd_we_ex      = we;
        bus.is_load_ex    = ld;
        bus.funct3_ex     = f3;
        bus.ld_adr_lo_ex  = lo;
        bus.alu_result_ex = alu;
        t0 = cyc;
        nxt();
        bus.cpu_stat_wb = 1'b0;
        run_low = 0;
        if (ld && rv_dly > 0) begin
            repeat (rv_dly - 1) begin
                @(negedge clk);
                if (!bus.wb_run) run_low++;
                nxt();
            end
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = rdata;
            @(negedge clk);
            if (!bus.wb_run) run_low++;
            nxt();
            bus.dmem_rvalid = 1'b0;
        end
        if (mon_n > 0) begin
            bus.rf_we_mon = 1'b1;
            repeat (mon_n) nxt();
            bus.rf_we_mon = 1'b0;
        end
        repeat (4) nxt();
    endtask

    initial begin
        int t0, s0, d0;
        bus.stall = 0; bus.cpu_stat_wb = 0; bus.rd_adr_ex = 0; bus.rd_we_ex = 0;
        bus.is_load_ex = 0; bus.funct3_ex = 0; bus.ld_adr_lo_ex = 0; bus.alu_result_ex = 0;
        bus.dmem_rvalid = 0; bus.dmem_rdata = 0; bus.rf_we_mon = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_run", {31'd0, bus.wb_run}, 32'd0);
        chk("rst_done", {31'd0, bus.wb_done}, 32'd0);
        chk("rst_strb", {31'd0, bus.wbk_rd_reg_wb}, 32'd0);
        chk("rst_adr", {27'd0, bus.rd_adr_wb}, 32'd0);
        chk("rst_data", bus.wbk_data_wb, 32'd0);
        chk("rst_err", {31'd0, bus.ld_err}, 32'd0);
        #1 rst_n = 1'b1;

        // ALU write
        s0 = n_strb; d0 = n_done;
        do_op(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h12345678, 0, 0, 0, t0);
        chk("alu_nstrb", n_strb - s0, 1);
        chk("alu_strb_cyc", strb_cyc, t0 + 1);
        chk("alu_adr", {27'd0, strb_adr}, 32'd5);
        chk("alu_data", strb_data, 32'h12345678);
        chk("alu_ndone", n_done - d0, 1);
        chk("alu_done_cyc", done_cyc, t0 + 2);

        // x0 and rd_we=0: no strobe, done still pulses
        s0 = n_strb;
        do_op(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEADBEEF, 0, 0, 0, t0);
        chk("x0_nstrb", n_strb - s0, 0);
        chk("x0_done_cyc", done_cyc, t0 + 2);
        do_op(5'd7, 1'b0, 1'b0, 3'd0, 2'd0, 32'hCAFEF00D, 0, 0, 0, t0);
        chk("nowe_nstrb", n_strb - s0, 0);
        chk("nowe_done_cyc", done_cyc, t0 + 2);
        chk("nowe_adr_hold", {27'd0, bus.rd_adr_wb}, 32'd7);

        // Load formatting
        do_op(5'd3, 1'b1, 1'b1, 3'b000, 2'd3, 32'h0, 2, 32'h80FF7F01, 0, t0);
        chk("lb_data", strb_data, 32'hFFFFFF80);
        chk("lb_strb_cyc", strb_cyc, t0 + 3);
        do_op(5'd3, 1'b1, 1'b1, 3'b100, 2'd3, 32'h0, 2, 32'h80FF7F01, 0, t0);
        chk("lbu_data", strb_data, 32'h00000080);
        do_op(5'd4, 1'b1, 1'b1, 3'b001, 2'd2, 32'h0, 1, 32'h80FF7F01, 0, t0);
        chk("lh_data", strb_data, 32'hFFFF80FF);
        do_op(5'd4, 1'b1, 1'b1, 3'b101, 2'd0, 32'h0, 1, 32'h80FF7F01, 0, t0);
        chk("lhu_data", strb_data, 32'h00007F01);
        do_op(5'd6, 1'b1, 1'b1, 3'b010, 2'd1, 32'h0, 1, 32'h80FF7F01, 0, t0);
        chk("lw_data", strb_data, 32'h80FF7F01);

        // Long load wait
        s0 = n_strb;
        do_op(5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 6, 32'hA5A5_0F0F, 0, t0);
        chk("wait_run_low", run_low, 0);
        chk("wait_strb_cyc", strb_cyc, t0 + 7);
        chk("wait_nstrb", n_strb - s0, 1);

        // rvalid while idle
        s0 = n_strb; d0 = n_done;
        nxt();
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h55555555;
        @(negedge clk);
        chk("idle_rv_run", {31'd0, bus.wb_run}, 32'd0);
        nxt();
        bus.dmem_rvalid = 1'b0;
        repeat (3) nxt();
        chk("idle_rv_nstrb", n_strb - s0, 0);

        // rvalid in the start cycle is ignored; the later one is taken
        bus.cpu_stat_wb = 1'b1; bus.rd_adr_ex = 5'd10; bus.rd_we_ex = 1'b1;
        bus.is_load_ex = 1'b1; bus.funct3_ex = 3'b010; bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = 32'h99999999;
        nxt();
        bus.cpu_stat_wb = 1'b0; bus.dmem_rvalid = 1'b0;
        repeat (3) nxt();
        @(negedge clk);
        chk("samecyc_run", {31'd0, bus.wb_run}, 32'd1);
        chk("samecyc_nstrb", n_strb - s0, 0);
        nxt();
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h11223344;
        nxt();
        bus.dmem_rvalid = 1'b0;
        repeat (3) nxt();
        chk("samecyc_data", strb_data, 32'h11223344);
        chk("samecyc_nstrb2", n_strb - s0, 1);

        // Monitor collision
        s0 = n_strb;
        do_op(5'd12, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0BADF00D, 0, 0, 3, t0);
        chk("mon_nstrb", n_strb - s0, 1);
        chk("mon_strb_cyc", strb_cyc, t0 + 4);
        chk("mon_done_cyc", done_cyc, t0 + 5);

        // Stalled start is ignored
        s0 = n_strb; d0 = n_done;
        nxt();
        bus.stall = 1'b1; bus.cpu_stat_wb = 1'b1; bus.is_load_ex = 1'b0; bus.rd_adr_ex = 5'd13;
        @(negedge clk);
        chk("stall_run", {31'd0, bus.wb_run}, 32'd0);
        nxt();
        bus.stall = 1'b0; bus.cpu_stat_wb = 1'b0;
        repeat (3) nxt();
        chk("stall_nstrb", n_strb - s0, 0);
        chk("stall_ndone", n_done - d0, 0);

        // Reset during LDWAIT aborts
        s0 = n_strb; d0 = n_done;
        bus.cpu_stat_wb = 1'b1; bus.rd_adr_ex = 5'd14; bus.rd_we_ex = 1'b1; bus.is_load_ex = 1'b1;
        nxt();
        bus.cpu_stat_wb = 1'b0;
        nxt();
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        nxt();
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h77777777;
        @(negedge clk);
        chk("rstld_run", {31'd0, bus.wb_run}, 32'd0);
        nxt();
        bus.dmem_rvalid = 1'b0;
        repeat (3) nxt();
        chk("rstld_nstrb", n_strb - s0, 0);
        chk("rstld_ndone", n_done - d0, 0);
        chk("rstld_adr", {27'd0, bus.rd_adr_wb}, 32'd0);

`ifdef WB_LDTIMEOUT_EN
        s0 = n_strb;
        do_op(5'd15, 1'b1, 1'b1, 3'b010, 2'd0, 32'hFFFFFFFF, 0, 0, 0, t0);
        repeat (8) nxt();
        chk("to_nstrb", n_strb - s0, 1);
        chk("to_adr", {27'd0, strb_adr}, 32'd15);
        chk("to_data", strb_data, 32'd0);
        chk("to_err", {31'd0, bus.ld_err}, 32'd1);
        do_op(5'd16, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1, 0, 0, 0, t0);
        chk("to_err_clr", {31'd0, bus.ld_err}, 32'd0);
`else
        chk("no_to_err", {31'd0, bus.ld_err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
